// File: rtl/quick_spi_master_mc.sv
// SPI master with configurable word width, runtime clock divider, all four
// CPOL/CPHA modes, MSB/LSB-first ordering and multiple active-low chip selects.
module quick_spi_master_mc #(
  parameter int DATA_WIDTH   = 8,
  parameter int CS_COUNT     = 1,
  parameter int DIV_WIDTH    = 8,
  parameter int CS_SEL_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [CS_SEL_WIDTH-1:0] cs_sel,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic                    lsb_first,
  input  logic [DIV_WIDTH-1:0]    clk_div,
  input  logic                    miso,
  output logic                    mosi,
  output logic                    sck,
  output logic [CS_COUNT-1:0]     cs_n,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    busy,
  output logic                    new_data
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CS_SETUP, TRANSFER, CS_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [DIV_WIDTH-1:0]    hp_q, hp_d, div_q, div_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    sck_q, sck_d, mosi_q, mosi_d, new_data_q, new_data_d;
  logic [CS_COUNT-1:0]     cs_n_q, cs_n_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d, tx_q, tx_d, rx_q, rx_d;
  logic                    cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic                    tick, lead;

  // Maps the k-th bit in wire order to its weight in the word.
  function automatic logic [BW-1:0] bit_pos(input logic [BW-1:0] k, input logic lsb);
    return lsb ? k : (BW'(DATA_WIDTH - 1) - k);
  endfunction

  function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] w, input logic [BW-1:0] pos);
    logic [DATA_WIDTH-1:0] s;
    s = w >> pos;
    return s[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] put_bit(input logic [DATA_WIDTH-1:0] w,
                                                    input logic [BW-1:0] pos, input logic b);
    logic [DATA_WIDTH-1:0] mask;
    mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << pos;
    return b ? (w | mask) : (w & ~mask);
  endfunction

  assign tick = (hp_q == div_q);
  assign lead = (sck_q == cpol_q);

  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    bit_d      = bit_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    data_out_d = data_out_q;
    new_data_d = 1'b0;
    tx_d       = tx_q;
    rx_d       = rx_q;
    div_d      = div_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    unique case (state_q)
      IDLE: begin
        sck_d  = cpol;
        mosi_d = 1'b0;
        cs_n_d = '1;
        hp_d   = '0;
        bit_d  = '0;
        if (start) begin
          state_d = CS_SETUP;
          tx_d    = data_in;
          div_d   = clk_div;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          for (int i = 0; i < CS_COUNT; i++) cs_n_d[i] = (32'(cs_sel) != 32'(i));
          if (!cpha) mosi_d = pick_bit(data_in, bit_pos('0, lsb_first));
        end
      end
      CS_SETUP: begin
        if (tick) begin
          hp_d    = '0;
          state_d = TRANSFER;
        end else begin
          hp_d = hp_q + DIV_WIDTH'(1);
        end
      end
      TRANSFER: begin
        if (tick) begin
          hp_d  = '0;
          sck_d = ~sck_q;
          // Leading edge moves SCK away from its idle level.
          if (lead) begin
            if (!cpha_q) rx_d = put_bit(rx_q, bit_pos(bit_q, lsb_q), miso);
            else         mosi_d = pick_bit(tx_q, bit_pos(bit_q, lsb_q));
          end else begin
            if (cpha_q) rx_d = put_bit(rx_q, bit_pos(bit_q, lsb_q), miso);
            bit_d = bit_q + BW'(1);
            if (bit_q == BW'(DATA_WIDTH - 1)) begin
              state_d = CS_HOLD;
            end else if (!cpha_q) begin
              mosi_d = pick_bit(tx_q, bit_pos(bit_q + BW'(1), lsb_q));
            end
          end
        end else begin
          hp_d = hp_q + DIV_WIDTH'(1);
        end
      end
      CS_HOLD: begin
        if (tick) begin
          hp_d       = '0;
          state_d    = IDLE;
          cs_n_d     = '1;
          mosi_d     = 1'b0;
          data_out_d = rx_q;
          new_data_d = 1'b1;
        end else begin
          hp_d = hp_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      hp_q       <= '0;
      bit_q      <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      data_out_q <= '0;
      new_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_q       <= hp_d;
      bit_q      <= bit_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      data_out_q <= data_out_d;
      new_data_q <= new_data_d;
    end
  end

  // Latched transfer configuration and shift data carry no reset.
  always_ff @(posedge clk) begin
    tx_q   <= tx_d;
    rx_q   <= rx_d;
    div_q  <= div_d;
    cpol_q <= cpol_d;
    cpha_q <= cpha_d;
    lsb_q  <= lsb_d;
  end

  assign mosi     = mosi_q;
  assign sck      = sck_q;
  assign cs_n     = cs_n_q;
  assign data_out = data_out_q;
  assign new_data = new_data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_quick_spi_master_mc.sv
// Self-checking bench for quick_spi_master_mc: a behavioural SPI slave watches
// SCK/MOSI, drives MISO, and transfers are checked against spec-level expectations.
module tb_quick_spi_master_mc;
  localparam int DW = 8, CSN = 4, DIVW = 8, SELW = 3;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [SELW-1:0] cs_sel = '0;
  logic cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [DIVW-1:0] clk_div = '0;
  logic miso = 1'b0;
  logic mosi, sck, busy, new_data;
  logic [CSN-1:0] cs_n;
  logic [DW-1:0] data_out;

  int checks = 0, failures = 0;

  int o_lat, o_pulses, o_cs_bad, o_busy_bad, o_toggles;
  logic [DW-1:0] o_rx, o_mosi;
  logic o_first_mosi, o_sck_end, o_busy_e0, o_idle_ok;

  quick_spi_master_mc #(.DATA_WIDTH(DW), .CS_COUNT(CSN), .DIV_WIDTH(DIVW), .CS_SEL_WIDTH(SELW)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
    .miso(miso), .mosi(mosi), .sck(sck), .cs_n(cs_n), .data_out(data_out),
    .busy(busy), .new_data(new_data)
  );

  always #5 clk = ~clk;

  function automatic logic [CSN-1:0] exp_cs(input int sel);
    logic [CSN-1:0] v;
    v = '1;
    for (int i = 0; i < CSN; i++) if (i == sel) v[i] = 1'b0;
    return v;
  endfunction

  function automatic int exp_lat(input int div);
    return (2 * DW + 2) * (div + 1);
  endfunction

  // Slave presents the k-th bit of its word in wire order.
  function automatic logic slave_bit(input logic [DW-1:0] w, input int k, input logic lsb);
    logic [DW-1:0] s;
    if (k >= DW) return 1'b0;
    s = w >> (lsb ? k : DW - 1 - k);
    return s[0];
  endfunction

  // Runs one transfer and records what the slave side observed.
  task automatic do_xfer(input logic [DW-1:0] din, input logic [DW-1:0] sw, input logic pol,
                         input logic pha, input logic lsb, input int div, input int sel,
                         input bit loop, input bit hold, input bit b2b, input bit noise);
    int k, cyc, idx;
    logic psck, pmosi, smp;
    logic [CSN-1:0] ecs;
    bit done;
    ecs = exp_cs(sel);
    k = 0; o_lat = -1; o_pulses = 0; o_cs_bad = 0; o_busy_bad = 0; o_toggles = 0;
    o_rx = '0; o_mosi = '0; o_first_mosi = 1'b0; o_sck_end = 1'b0;
    data_in = din; cpol = pol; cpha = pha; lsb_first = lsb;
    clk_div = DIVW'(div); cs_sel = SELW'(sel);
    miso = loop ? mosi : slave_bit(sw, 0, lsb);
    if (!b2b) begin
      start = 1'b0;
      @(posedge clk); #1;
      o_idle_ok = (sck === pol);
      start = 1'b1;
    end else begin
      o_idle_ok = 1'b1;
    end
    @(posedge clk); #1;
    o_busy_e0 = busy;
    if (!hold) start = 1'b0;
    if (cs_n !== ecs) o_cs_bad++;
    psck = sck; pmosi = mosi;
    miso = loop ? mosi : slave_bit(sw, 0, lsb);
    cyc = 0; done = 0;
    while (!done && cyc < 6000) begin
      if (noise) begin
        start = 1'($urandom); data_in = DW'($urandom); cpol = 1'($urandom);
        cpha = 1'($urandom); lsb_first = 1'($urandom); clk_div = DIVW'($urandom);
        cs_sel = SELW'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (new_data === 1'b1) begin
        if (!hold) start = 1'b0;
        o_lat = cyc; o_pulses++; o_rx = data_out; o_sck_end = sck;
        if (busy !== 1'b0) o_busy_bad++;
        if (cs_n !== '1) o_cs_bad++;
        done = 1;
      end else begin
        if (busy !== 1'b1) o_busy_bad++;
        if (cs_n !== ecs) o_cs_bad++;
        if (sck !== psck) begin
          o_toggles++;
          smp = pha ? (o_toggles % 2 == 0) : (o_toggles % 2 == 1);
          if (smp && k < DW) begin
            idx = lsb ? k : DW - 1 - k;
            o_mosi = o_mosi | (DW'(pmosi) << idx);
            if (k == 0) o_first_mosi = pmosi;
            k++;
          end
        end
        psck = sck; pmosi = mosi;
        miso = loop ? mosi : slave_bit(sw, k, lsb);
      end
    end
    if (!hold) begin
      start = 1'b0;
      @(posedge clk); #1;
      if (new_data !== 1'b0) o_pulses++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({mosi, sck, busy, new_data} !== 4'b0000) begin failures++;
      $display("FAIL reset_ctrl: mosi/sck/busy/new_data=%b required 0000", {mosi, sck, busy, new_data}); end
    checks++; if (cs_n !== '1) begin failures++; $display("FAIL reset_cs_n: got %h required %h", cs_n, {CSN{1'b1}}); end
    checks++; if (data_out !== '0) begin failures++; $display("FAIL reset_data_out: got %h required 00", data_out); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mode0_loop();
    do_xfer(8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (o_lat !== 36) begin failures++; $display("FAIL m0_latency: got %0d required 36", o_lat); end
    checks++; if (o_rx !== 8'hA5) begin failures++; $display("FAIL m0_data_out: got %h required a5", o_rx); end
    checks++; if (o_mosi !== 8'hA5) begin failures++; $display("FAIL m0_mosi_bits: got %h required a5", o_mosi); end
    checks++; if (o_pulses !== 1) begin failures++; $display("FAIL m0_pulses: got %0d required 1", o_pulses); end
    checks++; if (o_cs_bad !== 0 || o_busy_bad !== 0 || o_busy_e0 !== 1'b1) begin failures++;
      $display("FAIL m0_cs_busy: cs_bad=%0d busy_bad=%0d busy_e0=%b required 0 0 1", o_cs_bad, o_busy_bad, o_busy_e0); end
  endtask

  task automatic test_mode3();
    logic [DW-1:0] din;
    din = DW'($urandom);
    do_xfer(din, 8'h3C, 1'b1, 1'b1, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (o_lat !== 54) begin failures++; $display("FAIL m3_latency: got %0d required 54", o_lat); end
    checks++; if (o_rx !== 8'h3C) begin failures++; $display("FAIL m3_data_out: got %h required 3c", o_rx); end
    checks++; if (o_mosi !== din) begin failures++; $display("FAIL m3_mosi_word: got %h required %h", o_mosi, din); end
    checks++; if (o_idle_ok !== 1'b1 || o_sck_end !== 1'b1) begin failures++;
      $display("FAIL m3_sck_idle: before=%b after=%b required 1 1", o_idle_ok, o_sck_end); end
    checks++; if (o_toggles !== 2 * DW) begin failures++; $display("FAIL m3_toggles: got %0d required %0d", o_toggles, 2 * DW); end
  endtask

  task automatic test_lsb_first();
    do_xfer(8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (o_first_mosi !== 1'b1) begin failures++; $display("FAIL lsb_first_bit: got %b required 1", o_first_mosi); end
    checks++; if (o_mosi !== 8'h01) begin failures++; $display("FAIL lsb_mosi_word: got %h required 01", o_mosi); end
    checks++; if (o_rx !== 8'h80) begin failures++; $display("FAIL lsb_data_out: got %h required 80", o_rx); end
  endtask

  task automatic test_cs_select();
    logic [DW-1:0] sw;
    sw = DW'($urandom);
    do_xfer(8'h5A, sw, 1'b0, 1'b1, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (o_cs_bad !== 0) begin failures++; $display("FAIL cs_sel2: %0d cycles with cs_n != %h", o_cs_bad, exp_cs(2)); end
    checks++; if (o_rx !== sw) begin failures++; $display("FAIL cs_sel2_data: got %h required %h", o_rx, sw); end
    do_xfer(8'hC3, ~sw, 1'b1, 1'b0, 1'b0, 0, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (o_cs_bad !== 0) begin failures++; $display("FAIL cs_sel5: %0d cycles with cs_n != f", o_cs_bad); end
    checks++; if (o_pulses !== 1 || o_lat !== exp_lat(0)) begin failures++;
      $display("FAIL cs_sel5_pulse: pulses=%0d lat=%0d required 1 %0d", o_pulses, o_lat, exp_lat(0)); end
    checks++; if (o_rx !== ~sw) begin failures++; $display("FAIL cs_sel5_data: got %h required %h", o_rx, ~sw); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] sw;
    for (int t = 0; t < 3; t++) begin
      sw = DW'($urandom);
      do_xfer(DW'($urandom), sw, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b1, (t != 0), 1'b0);
      checks++; if (o_lat !== 18 || o_busy_e0 !== 1'b1) begin failures++;
        $display("FAIL b2b_latency[%0d]: lat=%0d busy_e0=%b required 18 1", t, o_lat, o_busy_e0); end
      checks++; if (o_rx !== sw || o_busy_bad !== 0) begin failures++;
        $display("FAIL b2b_data[%0d]: got %h busy_bad=%0d required %h 0", t, o_rx, o_busy_bad, sw); end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || new_data !== 1'b0) begin failures++;
      $display("FAIL b2b_stop: busy=%b new_data=%b required 0 0", busy, new_data); end
  endtask

  task automatic test_reset_abort();
    int extra;
    logic [DW-1:0] sw;
    data_in = 8'hF0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd1; cs_sel = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || cs_n[0] !== 1'b0) begin failures++;
      $display("FAIL abort_midway: busy=%b cs_n=%h required busy 1 cs_n[0] 0", busy, cs_n); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (cs_n !== '1 || {busy, sck, mosi, new_data} !== 4'b0000) begin failures++;
      $display("FAIL abort_state: cs_n=%h busy/sck/mosi/new_data=%b required f 0000", cs_n, {busy, sck, mosi, new_data}); end
    checks++; if (data_out !== '0) begin failures++; $display("FAIL abort_data_out: got %h required 00", data_out); end
    rst = 1'b1;
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (new_data !== 1'b0 || busy !== 1'b0) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL abort_quiet: %0d active cycles required 0", extra); end
    sw = DW'($urandom);
    do_xfer(8'h96, sw, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (o_lat !== 36 || o_rx !== sw || o_mosi !== 8'h96) begin failures++;
      $display("FAIL abort_recover: lat=%0d rx=%h mosi=%h required 36 %h 96", o_lat, o_rx, o_mosi, sw); end
  endtask

  task automatic test_random();
    logic [DW-1:0] din, sw;
    logic pol, pha, lsb;
    int div, sel;
    for (int t = 0; t < 8; t++) begin
      din = DW'($urandom); sw = DW'($urandom);
      pol = 1'($urandom); pha = 1'($urandom); lsb = 1'($urandom);
      div = (t == 7) ? 255 : int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 7));
      do_xfer(din, sw, pol, pha, lsb, div, sel, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (o_lat !== exp_lat(div)) begin failures++;
        $display("FAIL rnd_latency[%0d]: got %0d required %0d", t, o_lat, exp_lat(div)); end
      checks++; if (o_rx !== sw || o_mosi !== din) begin failures++;
        $display("FAIL rnd_data[%0d]: rx=%h mosi=%h required %h %h", t, o_rx, o_mosi, sw, din); end
      checks++; if (o_pulses !== 1 || o_cs_bad !== 0 || o_idle_ok !== 1'b1 || o_sck_end !== pol) begin failures++;
        $display("FAIL rnd_ctrl[%0d]: pulses=%0d cs_bad=%0d idle=%b sck_end=%b required 1 0 1 %b",
                 t, o_pulses, o_cs_bad, o_idle_ok, o_sck_end, pol); end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_loop();
    test_mode3();
    test_lsb_first();
    test_cs_select();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
